// File: rtl/gmii_arb_pkg.sv
// Shared types and defaults for the GMII transmit arbiter.
package gmii_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    IFG
  } arb_state_t;

  localparam int unsigned GMII_IFG_DEFAULT = 12;
  localparam int unsigned GMII_MAX_FRAME   = 1526;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester strictly after last_win_i, wrapping.
module rr_pick #(
  parameter int unsigned N_SRC = 2
) (
  input  logic [N_SRC-1:0]         req_i,
  input  logic [$clog2(N_SRC)-1:0] last_win_i,
  output logic [N_SRC-1:0]         gnt_o,
  output logic [$clog2(N_SRC)-1:0] idx_o,
  output logic                     valid_o
);

  localparam int unsigned IW = $clog2(N_SRC);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      cand     = (int'(last_win_i) + off) % N_SRC;
      cand_idx = IW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the PCS GMII transmit path.
// Optional frame-length watchdog enabled by defining GMII_ARB_WATCHDOG_EN.
module gmii_tx_arbiter
  import gmii_arb_pkg::*;
#(
  parameter int unsigned N_SRC           = 2,
  parameter int unsigned IFG_CYCLES      = GMII_IFG_DEFAULT,
  parameter int unsigned START_TIMEOUT   = 64,
  parameter int unsigned MAX_FRAME_BYTES = GMII_MAX_FRAME
) (
  input  logic               gmii_clk,
  input  logic               rst_n,
  input  logic               link_up,
  input  logic [N_SRC-1:0]   src_req,
  output logic [N_SRC-1:0]   src_gnt,
  input  logic [8*N_SRC-1:0] src_txd,
  input  logic [N_SRC-1:0]   src_tx_en,
  input  logic [N_SRC-1:0]   src_tx_er,
  output logic [7:0]         gmii_tx_data,
  output logic               gmii_tx_en,
  output logic               gmii_tx_err,
  output logic               busy,
  output logic [15:0]        frames_sent
`ifdef GMII_ARB_WATCHDOG_EN
  ,
  output logic               abort_pulse
`endif
);

  localparam int unsigned IW = $clog2(N_SRC);
  localparam int unsigned CW = $clog2(max_u(IFG_CYCLES, START_TIMEOUT) + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] last_win_q, last_win_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          er_q, er_d;
  logic [15:0]   frames_q, frames_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N_SRC-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  logic [7:0] sel_txd;
  logic       sel_en;
  logic       sel_er;
  logic       sel_req;
  logic       wd_hit;

  rr_pick #(
    .N_SRC(N_SRC)
  ) u_pick (
    .req_i      (src_req),
    .last_win_i (last_win_q),
    .gnt_o      (pick_gnt),
    .idx_o      (pick_idx),
    .valid_o    (pick_valid)
  );

  // last_win_q always names the granted source while in GRANT/XFER.
  always_comb begin
    sel_txd = '0;
    sel_en  = 1'b0;
    sel_er  = 1'b0;
    sel_req = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (last_win_q == IW'(i)) begin
        sel_txd = src_txd[8*i +: 8];
        sel_en  = src_tx_en[i];
        sel_er  = src_tx_er[i];
        sel_req = src_req[i];
      end
    end
  end

`ifdef GMII_ARB_WATCHDOG_EN
  localparam int unsigned BW = $clog2(MAX_FRAME_BYTES + 1);

  logic [BW-1:0] bcnt_q;
  logic          abort_q;

  // bcnt_q holds the number of bytes already emitted in the current frame.
  always_ff @(posedge gmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= (state_q == XFER) && sel_en && wd_hit;
      if (state_q == GRANT && sel_en) begin
        bcnt_q <= BW'(1);
      end else if (state_q == XFER && sel_en && !wd_hit) begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  assign wd_hit      = (bcnt_q == BW'(MAX_FRAME_BYTES));
  assign abort_pulse = abort_q;
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    gnt_d      = gnt_q;
    data_d     = '0;
    en_d       = 1'b0;
    er_d       = 1'b0;
    frames_d   = frames_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (link_up && pick_valid) begin
          gnt_d      = pick_gnt;
          last_win_d = pick_idx;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (sel_en) begin
          data_d  = sel_txd;
          en_d    = 1'b1;
          er_d    = sel_er;
          state_d = XFER;
        end else if (!sel_req || cnt_q == CW'(START_TIMEOUT - 1)) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (sel_en && wd_hit) begin
          en_d    = 1'b1;
          er_d    = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = IFG;
        end else if (sel_en) begin
          data_d = sel_txd;
          en_d   = 1'b1;
          er_d   = sel_er;
        end else begin
          gnt_d    = '0;
          frames_d = frames_q + 16'd1;
          cnt_d    = '0;
          state_d  = IFG;
        end
      end
      IFG: begin
        if (cnt_q == CW'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_win_q <= IW'(N_SRC - 1);
      gnt_q      <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      frames_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      gnt_q      <= gnt_d;
      data_q     <= data_d;
      en_q       <= en_d;
      er_q       <= er_d;
      frames_q   <= frames_d;
      cnt_q      <= cnt_d;
    end
  end

  assign src_gnt      = gnt_q;
  assign gmii_tx_data = data_q;
  assign gmii_tx_en   = en_q;
  assign gmii_tx_err  = er_q;
  assign busy         = (state_q != IDLE);
  assign frames_sent  = frames_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: source models push expected bytes/grants, a monitor pops and compares.
module tb_gmii_tx_arbiter;

  localparam int N = 2;

  logic           gmii_clk = 1'b0;
  logic           rst_n;
  logic           link_up;
  logic [N-1:0]   src_req;
  logic [N-1:0]   src_gnt;
  logic [8*N-1:0] src_txd;
  logic [N-1:0]   src_tx_en;
  logic [N-1:0]   src_tx_er;
  logic [7:0]     gmii_tx_data;
  logic           gmii_tx_en;
  logic           gmii_tx_err;
  logic           busy;
  logic [15:0]    frames_sent;
`ifdef GMII_ARB_WATCHDOG_EN
  logic           abort_pulse;
`endif

  int total = 0;
  int bad   = 0;

  int pend[N];
  int flen[N];
  int pos[N];
  int seq[N];
  int fr_cnt[N];
  bit stall[N];
  bit noise[N];

  logic [7:0] expq[$];
  int         gq[$];
  int         en_cycles = 0;
  int         aborts    = 0;

  gmii_tx_arbiter #(
    .N_SRC          (N),
    .IFG_CYCLES     (12),
    .START_TIMEOUT  (64),
    .MAX_FRAME_BYTES(1526)
  ) dut (
    .gmii_clk    (gmii_clk),
    .rst_n       (rst_n),
    .link_up     (link_up),
    .src_req     (src_req),
    .src_gnt     (src_gnt),
    .src_txd     (src_txd),
    .src_tx_en   (src_tx_en),
    .src_tx_er   (src_tx_er),
    .gmii_tx_data(gmii_tx_data),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_err (gmii_tx_err),
    .busy        (busy),
    .frames_sent (frames_sent)
`ifdef GMII_ARB_WATCHDOG_EN
    ,
    .abort_pulse (abort_pulse)
`endif
  );

  always #4 gmii_clk = ~gmii_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_frames(input int id, input int target, input int budget, input string nm);
    for (int c = 0; c < budget && fr_cnt[id] < target; c++) @(negedge gmii_clk);
    chk(nm, (fr_cnt[id] >= target) ? target : fr_cnt[id], target);
  endtask

  // Source models: respond to their grant with a frame of flen bytes.
  initial begin
    logic [7:0] b;
    src_req   = '0;
    src_txd   = '0;
    src_tx_en = '0;
    src_tx_er = '0;
    for (int i = 0; i < N; i++) begin
      pos[i] = -1; seq[i] = 0; fr_cnt[i] = 0;
    end
    forever begin
      @(posedge gmii_clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < N; i++) pos[i] = -1;
        src_req   = '0;
        src_tx_en = '0;
        src_txd   = '0;
        expq.delete();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (pos[i] < 0 && src_gnt[i] && !stall[i] && pend[i] > 0) pos[i] = 0;
          if (pos[i] >= 0) begin
            if (pos[i] < flen[i]) begin
              b = 8'(i * 100 + seq[i] * 13 + pos[i]);
              src_txd[8*i +: 8] = b;
              src_tx_en[i] = 1'b1;
              expq.push_back(b);
              pos[i]++;
            end else begin
              src_txd[8*i +: 8] = '0;
              src_tx_en[i] = 1'b0;
              pos[i] = -1;
              pend[i]--;
              fr_cnt[i]++;
              seq[i]++;
            end
          end else if (noise[i]) begin
            src_txd[8*i +: 8] = 8'($urandom);
            src_tx_en[i] = 1'($urandom);
          end else begin
            src_txd[8*i +: 8] = '0;
            src_tx_en[i] = 1'b0;
          end
          src_req[i] = (pend[i] > 0) || (pos[i] >= 0);
        end
      end
    end
  end

  // Monitor: pops expected grants and bytes as the DUT presents them.
  initial begin
    logic [N-1:0] prev_gnt;
    logic [7:0]   e8;
    int           e;
    bit           prev_en, seen, wd_ignore;
    int           low;
    prev_gnt = '0; prev_en = 0; seen = 0; low = 0; wd_ignore = 0;
    forever begin
      @(negedge gmii_clk);
      if (!rst_n) begin
        prev_gnt = '0; prev_en = 0; seen = 0; low = 0; wd_ignore = 0;
      end else begin
        if (src_gnt != '0 && prev_gnt == '0) begin
          chk("gnt_onehot", $onehot(src_gnt), 1);
          if (gq.size() == 0) chk("gnt_unexpected", src_gnt, 0);
          else begin
            e = gq.pop_front();
            chk("gnt_order", src_gnt, 1 << e);
          end
        end
        if (gmii_tx_en) begin
          if (!prev_en && seen) chk("ifg_ge14", (low >= 14) ? 14 : low, 14);
`ifdef GMII_ARB_WATCHDOG_EN
          if (gmii_tx_err) begin
            chk("abort_data", gmii_tx_data, 0);
            chk("abort_pulse", abort_pulse, 1);
            aborts++;
            wd_ignore = 1;
          end else
`endif
          if (!wd_ignore) begin
            if (expq.size() == 0) chk("data_unexpected", gmii_tx_data, -1);
            else begin
              e8 = expq.pop_front();
              chk("data", gmii_tx_data, e8);
              chk("err", gmii_tx_err, 0);
            end
          end
          seen = 1;
          low  = 0;
          en_cycles++;
        end else begin
          low++;
        end
        prev_en  = gmii_tx_en;
        prev_gnt = src_gnt;
      end
    end
  end

  initial begin
    int e0, f0, f1, dur;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; flen[i] = 0; stall[i] = 0; noise[i] = 0;
    end
    link_up = 1'b1;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", src_gnt, 0);
    chk("rst_en", gmii_tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    repeat (3) @(negedge gmii_clk);
    rst_n = 1'b1;
    @(negedge gmii_clk);
    chk("post_rst_gnt", src_gnt, 0);
    chk("post_rst_data", gmii_tx_data, 0);

    // Single source, 60 bytes, with noise on the idle source
    noise[1] = 1;
    gq.push_back(0);
    e0 = en_cycles;
    flen[0] = 60; pend[0] = 1;
    @(negedge gmii_clk);
    chk("req_seen_no_gnt_yet", src_gnt, 0);
    @(negedge gmii_clk);
    chk("gnt_after_1", src_gnt, 1);
    wait_frames(0, 1, 300, "t1_done");
    repeat (20) @(negedge gmii_clk);
    chk("t1_bytes", en_cycles - e0, 60);
    chk("t1_frames", frames_sent, 1);
    chk("t1_busy", busy, 0);
    noise[1] = 0;

    // Two continuous requesters, last_win=0 so source 1 goes first
    gq.push_back(1); gq.push_back(0); gq.push_back(1); gq.push_back(0);
    flen[0] = 64; flen[1] = 64;
    pend[0] = 2;  pend[1] = 2;
    wait_frames(0, 3, 2000, "t2_src0_done");
    wait_frames(1, 2, 2000, "t2_src1_done");
    repeat (20) @(negedge gmii_clk);
    chk("t2_frames", frames_sent, 5);

    // Link down blocks grant; link drop mid-frame does not truncate
    link_up = 1'b0;
    gq.push_back(1);
    flen[1] = 20; pend[1] = 1;
    repeat (10) @(negedge gmii_clk);
    chk("link_block_gnt", src_gnt, 0);
    chk("link_block_busy", busy, 0);
    e0 = en_cycles;
    link_up = 1'b1;
    @(negedge gmii_clk);
    chk("link_gnt", src_gnt, 2);
    for (int c = 0; c < 10 && !gmii_tx_en; c++) @(negedge gmii_clk);
    repeat (5) @(negedge gmii_clk);
    link_up = 1'b0;
    wait_frames(1, 3, 200, "t3_done");
    repeat (20) @(negedge gmii_clk);
    chk("t3_bytes", en_cycles - e0, 20);
    chk("t3_frames", frames_sent, 6);
    gq.push_back(0);
    flen[0] = 5; pend[0] = 1;
    repeat (10) @(negedge gmii_clk);
    chk("link_block2_gnt", src_gnt, 0);
    link_up = 1'b1;
    wait_frames(0, 4, 200, "t3b_done");
    repeat (20) @(negedge gmii_clk);
    chk("t3b_frames", frames_sent, 7);

    // Stalled source times out after 64 cycles, then source 0 is served
    gq.push_back(1); gq.push_back(0);
    stall[1] = 1; pend[1] = 1;
    flen[0] = 10; pend[0] = 1;
    for (int c = 0; c < 50 && !src_gnt[1]; c++) @(negedge gmii_clk);
    chk("to_gnt_seen", src_gnt[1], 1);
    e0 = en_cycles;
    dur = 0;
    while (src_gnt[1] && dur < 200) begin
      dur++;
      @(negedge gmii_clk);
    end
    chk("to_duration", dur, 64);
    chk("to_no_tx", en_cycles - e0, 0);
    pend[1] = 0;
    wait_frames(0, 5, 300, "t4_done");
    stall[1] = 0;
    repeat (20) @(negedge gmii_clk);
    chk("t4_frames", frames_sent, 8);

`ifdef GMII_ARB_WATCHDOG_EN
    gq.push_back(1);
    e0 = en_cycles;
    flen[1] = 2000; pend[1] = 1;
    for (int c = 0; c < 3000 && aborts == 0; c++) @(negedge gmii_clk);
    chk("wd_aborted", aborts, 1);
    chk("wd_bytes", en_cycles - e0, 1527);
    repeat (3) @(negedge gmii_clk);
    chk("wd_frames", frames_sent, 8);
    chk("wd_en_low", gmii_tx_en, 0);
    chk("wd_pulse_low", abort_pulse, 0);
    rst_n = 1'b0;
    pend[1] = 0;
    repeat (3) @(negedge gmii_clk);
    gq.delete();
    rst_n = 1'b1;
    @(negedge gmii_clk);
`endif

    // Asynchronous reset mid-frame, then source 0 wins first
    gq.push_back(0);
    e0 = en_cycles;
    flen[0] = 40; pend[0] = 1;
    for (int c = 0; c < 100 && (en_cycles - e0) < 10; c++) @(negedge gmii_clk);
    chk("t5_midframe", gmii_tx_en, 1);
    #2 rst_n = 1'b0;
    pend[0] = 0; pend[1] = 0;
    #1;
    chk("arst_en", gmii_tx_en, 0);
    chk("arst_data", gmii_tx_data, 0);
    chk("arst_err", gmii_tx_err, 0);
    chk("arst_gnt", src_gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_frames", frames_sent, 0);
    repeat (3) @(negedge gmii_clk);
    gq.delete();
    rst_n = 1'b1;
    f0 = fr_cnt[0]; f1 = fr_cnt[1];
    gq.push_back(0); gq.push_back(1);
    flen[0] = 8; flen[1] = 8;
    pend[0] = 1; pend[1] = 1;
    @(negedge gmii_clk);
    @(negedge gmii_clk);
    chk("rst_first_win", src_gnt, 1);
    wait_frames(0, f0 + 1, 300, "t5_src0_done");
    wait_frames(1, f1 + 1, 300, "t5_src1_done");
    repeat (20) @(negedge gmii_clk);
    chk("t5_frames", frames_sent, 2);

    chk("expq_empty", expq.size(), 0);
    chk("gq_empty", gq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
